// File: rtl/data_scratchpad_if.sv
// data_scratchpad_if: request/response valid-ready bundle for the MEM-stage scratchpad
interface data_scratchpad_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  modport master (
    output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/data_scratchpad.sv
// data_scratchpad: single-port byte-lane data memory with pipelined, back-pressured responses
module data_scratchpad #(
  parameter int    DEPTH_WORDS  = 4096,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input logic             clock,
  input logic             reset,
  data_scratchpad_if.slave io
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]             r_mem [DEPTH_WORDS];
  logic                    w_stall;
  logic                    w_acc;
  logic                    w_err;
  logic [AW-1:0]           w_idx;
  logic [3:0]              w_be;
  logic [31:0]             w_wlane;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [31:0]             w_ext;
  logic                    w_unused;
  logic [READ_LATENCY:0]   r_v;
  logic [31:0]             r_raw;
  logic [1:0]              r_lo;
  logic [1:0]              r_size;
  logic                    r_uns;
  logic                    r_wr;
  logic                    r_err;
  logic [31:0]             r_d [1:READ_LATENCY];
  logic [READ_LATENCY:1]   r_e;

  assign w_stall      = io.resp_valid && !io.resp_ready;
  assign io.req_ready = !w_stall;
  assign w_acc        = io.req_valid && io.req_ready;
  assign w_idx        = io.req_addr[AW+1:2];
  assign w_unused     = &{1'b0, io.req_addr[31:AW+2]};
  assign w_byte       = r_raw[{r_lo, 3'b000} +: 8];
  assign w_half       = r_lo[1] ? r_raw[31:16] : r_raw[15:0];

  always_comb begin
    w_err   = io.req_size == 2'd3 || (io.req_size == 2'd1 && io.req_addr[0]) ||
              (io.req_size == 2'd2 && io.req_addr[1:0] != 2'd0);
    w_be    = io.req_size == 2'd0 ? 4'b0001 << io.req_addr[1:0] :
              io.req_size == 2'd1 ? (io.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wlane = io.req_size == 2'd0 ? {4{io.req_wdata[7:0]}} :
              io.req_size == 2'd1 ? {2{io.req_wdata[15:0]}} : io.req_wdata;
  end

  always_comb begin
    w_ext = (r_wr || r_err) ? 32'h0 :
            r_size == 2'd0 ? {{24{!r_uns && w_byte[7]}}, w_byte} :
            r_size == 2'd1 ? {{16{!r_uns && w_half[15]}}, w_half} : r_raw;
  end

  always_ff @(posedge clock) begin
    if (w_acc && io.req_write && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v <= '0;
      r_e <= '0;
      for (int i = 1; i <= READ_LATENCY; i++) r_d[i] <= '0;
    end else if (!w_stall) begin
      r_v    <= {r_v[READ_LATENCY-1:0], w_acc};
      r_raw  <= r_mem[w_idx];
      r_lo   <= io.req_addr[1:0];
      r_size <= io.req_size;
      r_uns  <= io.req_unsigned;
      r_wr   <= io.req_write;
      r_err  <= w_err;
      r_d[1] <= w_ext;
      r_e[1] <= r_err;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        r_d[i] <= r_d[i-1];
        r_e[i] <= r_e[i-1];
      end
    end
  end

  assign io.resp_valid = r_v[READ_LATENCY];
  assign io.resp_data  = r_d[READ_LATENCY];
  assign io.resp_err   = r_e[READ_LATENCY];
endmodule

// File: tb/tb_data_scratchpad.sv
// tb_data_scratchpad: scoreboard bench for data_scratchpad (16 words, read latency 2)
module tb_data_scratchpad;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  int n_resp  = 0;
  logic [32:0] q[$];
  logic [31:0] ref_mem [16];
  logic [32:0] mon_e;

  always #5 clock = ~clock;

  data_scratchpad_if io();

  data_scratchpad #(.DEPTH_WORDS(16), .READ_LATENCY(2), .INIT_FILE("")) dut (
    .clock(clock),
    .reset(reset),
    .io(io)
  );

  // reference model: updates ref_mem on stores, returns {err, data} expected for the response
  function automatic logic [32:0] model(input logic w, input logic [1:0] sz, input logic u,
                                        input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    int idx;
    int lane;
    idx  = int'(a[5:2]);
    lane = int'(a[1:0]);
    word = ref_mem[idx];
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) return {1'b1, 32'h0};
    if (w) begin
      if (sz == 2'd0) word[lane*8 +: 8] = wd[7:0];
      else if (sz == 2'd1) word[(lane/2)*16 +: 16] = wd[15:0];
      else word = wd;
      ref_mem[idx] = word;
      return 33'h0;
    end
    b = word[lane*8 +: 8];
    h = word[(lane/2)*16 +: 16];
    if (sz == 2'd0) return {1'b0, u ? {24'h0, b} : {{24{b[7]}}, b}};
    if (sz == 2'd1) return {1'b0, u ? {16'h0, h} : {{16{h[15]}}, h}};
    return {1'b0, word};
  endfunction

  // response side of the scoreboard
  always @(negedge clock) begin
    if (!reset && io.resp_valid && io.resp_ready) begin
      n_tests++;
      n_resp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got err=%0b data=%h, required no response", io.resp_err, io.resp_data);
      end else begin
        mon_e = q.pop_front();
        if ({io.resp_err, io.resp_data} !== mon_e) begin
          n_fail++;
          $display("FAIL resp_data: got err=%0b data=%h, required err=%0b data=%h",
                   io.resp_err, io.resp_data, mon_e[32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd);
    logic rdy;
    bit done;
    done = 0;
    io.req_valid = 1'b1;
    io.req_write = w;
    io.req_size = sz;
    io.req_unsigned = u;
    io.req_addr = a;
    io.req_wdata = wd;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      rdy = io.req_ready;
      @(posedge clock);
      done = rdy;
    end
    #1 io.req_valid = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL accept_timeout: addr=%h not accepted, required accept within 40 cycles", a);
    end else q.push_back(model(w, sz, u, a, wd));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clock);
      idle = q.size() == 0 && !io.resp_valid;
    end
    n_tests++;
    if (!idle) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests += 3;
    if (io.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", io.resp_valid); end
    if (io.resp_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", io.resp_data); end
    if (io.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", io.resp_err); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if (io.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 1", io.req_ready); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_subword();
    send(1, 2'd2, 0, 32'h0, 32'h8070F0A5);
    wait_idle();
    send(0, 2'd0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_tests++;
      if (io.resp_valid !== (c == 2)) begin
        n_fail++;
        $display("FAIL latency: cycle %0d after accept valid=%b, required %b", c, io.resp_valid, c == 2);
      end
    end
    @(posedge clock);
    #1;
    send(0, 2'd0, 1, 32'h2, 32'h0);
    send(0, 2'd1, 0, 32'h2, 32'h0);
    send(0, 2'd1, 1, 32'h0, 32'h0);
    send(0, 2'd0, 0, 32'h3, 32'h0);
    send(0, 2'd0, 0, 32'h1, 32'h0);
    wait_idle();
  endtask

  task automatic test_raw();
    send(1, 2'd2, 0, 32'h4, 32'hA1B2C3D4);
    send(1, 2'd0, 0, 32'h5, 32'h0000005A);
    send(0, 2'd2, 0, 32'h4, 32'h0);
    send(1, 2'd1, 0, 32'h6, 32'h1234BEEF);
    send(0, 2'd2, 0, 32'h4, 32'h0);
    wait_idle();
  endtask

  task automatic test_errors();
    send(1, 2'd2, 0, 32'h6, 32'hFFFFFFFF);
    send(0, 2'd2, 0, 32'h4, 32'h0);
    send(0, 2'd1, 0, 32'h3, 32'h0);
    send(1, 2'd3, 0, 32'h4, 32'h55555555);
    send(0, 2'd3, 0, 32'h4, 32'h0);
    send(1, 2'd1, 0, 32'h5, 32'h00001234);
    send(0, 2'd2, 1, 32'h7, 32'h0);
    send(0, 2'd2, 1, 32'h4, 32'h0);
    wait_idle();
  endtask

  task automatic test_alias();
    send(1, 2'd2, 0, 32'h40, 32'h11223344);
    send(0, 2'd2, 0, 32'h0, 32'h0);
    send(1, 2'd2, 0, 32'h38, 32'h0BADF00D);
    send(1, 2'd0, 0, 32'h12345679, 32'h00000099);
    send(0, 2'd2, 0, 32'h38, 32'h0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int r0;
    send(1, 2'd2, 0, 32'h8, 32'h01020304);
    send(1, 2'd2, 0, 32'hC, 32'hF0E0D0C0);
    wait_idle();
    r0 = n_resp;
    io.resp_ready = 1'b0;
    fork
      begin
        send(0, 2'd2, 0, 32'h0, 32'h0);
        send(0, 2'd2, 0, 32'h4, 32'h0);
        send(0, 2'd1, 0, 32'h8, 32'h0);
        send(0, 2'd0, 1, 32'hF, 32'h0);
      end
      begin
        logic [32:0] held;
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clock);
          seen = io.resp_valid;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL b2b_first: no response, required valid within 20 cycles"); end
        held = {io.resp_err, io.resp_data};
        for (int c = 0; c < 3; c++) begin
          @(negedge clock);
          n_tests += 2;
          if (io.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_req_ready: got %b, required 0", io.req_ready); end
          if ({io.resp_err, io.resp_data} !== held) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h, required %h", {io.resp_err, io.resp_data}, held);
          end
        end
        @(posedge clock);
        #1 io.resp_ready = 1'b1;
      end
    join
    wait_idle();
    n_tests++;
    if (n_resp - r0 !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d responses, required 4", n_resp - r0); end
  endtask

  task automatic test_reset_inflight();
    bit stale;
    send(1, 2'd2, 0, 32'h8, 32'hCAFEBABE);
    wait_idle();
    send(0, 2'd2, 0, 32'h0, 32'h0);
    send(0, 2'd2, 0, 32'h4, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (io.resp_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_valid: got %b, required 0", io.resp_valid); end
    q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (io.resp_valid) stale = 1;
    end
    n_tests++;
    if (stale) begin n_fail++; $display("FAIL inflight_stale: got a response after reset, required none"); end
    @(posedge clock);
    #1;
    send(0, 2'd2, 0, 32'h8, 32'h0);
    wait_idle();
  endtask

  initial begin
    io.req_valid = 1'b0;
    io.req_write = 1'b0;
    io.req_size = 2'd0;
    io.req_unsigned = 1'b0;
    io.req_addr = 32'h0;
    io.req_wdata = 32'h0;
    io.resp_ready = 1'b1;
    test_reset();
    test_subword();
    test_raw();
    test_errors();
    test_alias();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog");
  end
endmodule
